// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the uart transmit arbiter.
package uart_tx_arb_pkg;

    localparam int STATE_W = 3;
    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int BURST_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_SYNC      = 3'd0,
        ST_ARB       = 3'd1,
        ST_ACCEPT    = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_ACT  = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } arb_state_t;

    // Index following idx in round-robin order, wrapping at num_req.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int num_req);
        if (int'(idx) >= num_req - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    // Scan requesters starting at ptr; the first valid one wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 uart transmitter between NUM_REQ byte producers. A granted
// requester keeps the line until its LAST byte (or a MAX_BURST forced release),
// so packets never interleave; ownership rotates round-robin per packet.
//
// state      | meaning
// SYNC       | wait for the uart (which has no reset) to be fully idle
// ARB        | no owner; pick next requester round-robin
// ACCEPT     | owner granted; take its next byte on valid
// ISSUE      | one-cycle start strobe to the uart
// WAIT_ACT   | wait for uart to report active
// WAIT_DONE  | wait for uart done to rise
// WAIT_IDLE  | wait for uart done to fall, then release or continue packet
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Active,
    input  logic                 i_TX_Done,
    output logic                 o_Busy
);

    localparam logic [BURST_W-1:0] MAX_BURST_B = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_SAT   = '1;

    arb_state_t         state;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [BURST_W-1:0] burst_cnt_q;
    logic [7:0]         tx_byte_q;
    logic               last_q;
    logic               tx_dv_q;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [7:0]         sel_byte;
    logic               sel_last;
    logic               handshake;
    logic               burst_hit;

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid     (i_Req_Valid),
        .ptr       (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Route the owner's offered byte and last flag.
    always_comb begin
        sel_byte = '0;
        sel_last = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (owner_q == IDX_W'(r)) begin
                sel_byte = i_Req_Byte[8*r +: 8];
                sel_last = i_Req_Last[r];
            end
        end
    end

    // Only the owner sees ready, and only while a byte can be taken.
    assign o_Req_Ready = (state == ST_ACCEPT) ? (i_Req_Valid & grant_q) : '0;
    assign handshake   = |o_Req_Ready;
    assign burst_hit   = (MAX_BURST != 0) && (burst_cnt_q == MAX_BURST_B);

    assign o_Grant   = grant_q;
    assign o_TX_DV   = tx_dv_q;
    assign o_TX_Byte = tx_byte_q;
    assign o_Busy    = (state != ST_SYNC) && (state != ST_ARB);

    // Arbitration and uart sequencing FSM with latched byte, burst count and rr pointer.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= ST_SYNC;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            tx_byte_q   <= '0;
            last_q      <= 1'b0;
            tx_dv_q     <= 1'b0;
        end else begin
            tx_dv_q <= 1'b0;
            case (state)
                ST_SYNC: begin
                    if (!i_TX_Active && !i_TX_Done) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (pick_any) begin
                        grant_q <= pick_grant;
                        owner_q <= pick_idx;
                        state   <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (handshake) begin
                        tx_byte_q <= sel_byte;
                        last_q    <= sel_last;
                        if (burst_cnt_q != BURST_SAT) begin
                            burst_cnt_q <= burst_cnt_q + BURST_W'(1);
                        end
                        tx_dv_q   <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_ACT;
                end
                ST_WAIT_ACT: begin
                    if (i_TX_Active) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_TX_Done) begin
                        state <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!i_TX_Done) begin
                        if (last_q || burst_hit) begin
                            grant_q     <= '0;
                            rr_ptr_q    <= next_idx(owner_q, NUM_REQ);
                            burst_cnt_q <= '0;
                            state       <= ST_ARB;
                        end else begin
                            state <= ST_ACCEPT;
                        end
                    end
                end
                default: begin
                    state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: producers with randomized packets feed the DUT,
// a packet-level reference model predicts the transmit order, and a monitor
// checks every uart strobe plus handshake/protocol rules each cycle.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int MAX_BURST = 3;
    localparam int CPB       = 4;

    logic                 i_Clock = 1'b0;
    logic                 i_Reset = 1'b0;
    logic [NUM_REQ-1:0]   i_Req_Valid = '0;
    logic [8*NUM_REQ-1:0] i_Req_Byte = '0;
    logic [NUM_REQ-1:0]   i_Req_Last = '0;
    logic [NUM_REQ-1:0]   o_Req_Ready;
    logic [NUM_REQ-1:0]   o_Grant;
    logic                 o_TX_DV;
    logic [7:0]           o_TX_Byte;
    logic                 o_Busy;

    logic       uart_active = 1'b0;
    logic       uart_done   = 1'b0;
    int         u_cnt  = 0;
    int         u_dcnt = 0;
    logic [9:0] u_frame = '1;
    logic       tx_serial;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] src_q [NUM_REQ][$];
    logic [9:0] exp_q [$];
    int         model_ptr = 0;
    int         gap [NUM_REQ];
    int         grant_bytes [NUM_REQ];
    logic       last_popped [NUM_REQ];
    logic [NUM_REQ-1:0] hs = '0;
    bit         gap_en = 1'b0;

    logic [7:0] strobed_byte = '0;
    bit         stab_en = 1'b0;
    bit         prev_dv = 1'b0;
    logic [9:0] mon_e;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Req_Valid (i_Req_Valid),
        .i_Req_Byte  (i_Req_Byte),
        .i_Req_Last  (i_Req_Last),
        .o_Req_Ready (o_Req_Ready),
        .o_Grant     (o_Grant),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .i_TX_Active (uart_active),
        .i_TX_Done   (uart_done),
        .o_Busy      (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    // Uart transmitter behaviour (no reset): 10 bit frame, then done high for 2 cycles.
    always @(posedge i_Clock) begin
        if (uart_active) begin
            if (u_cnt == 10*CPB-1) begin
                uart_active <= 1'b0;
                uart_done   <= 1'b1;
                u_dcnt      <= 0;
            end else begin
                u_cnt <= u_cnt + 1;
            end
        end else if (uart_done) begin
            if (u_dcnt == 1) uart_done <= 1'b0;
            else             u_dcnt <= u_dcnt + 1;
        end else if (o_TX_DV) begin
            uart_active <= 1'b1;
            u_cnt       <= 0;
            u_frame     <= {1'b1, o_TX_Byte, 1'b0};
        end
    end
    assign tx_serial = uart_active ? u_frame[u_cnt/CPB] : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < NUM_REQ; r++) if (src_q[r].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Packet-level reference: owners chosen round-robin among requesters with data,
    // each grant runs to LAST or MAX_BURST bytes, next search starts after the owner.
    task automatic model_round();
        logic [8:0] m_q [NUM_REQ][$];
        logic [8:0] e;
        int r, cnt;
        bit found;
        for (int i = 0; i < NUM_REQ; i++) m_q[i] = src_q[i];
        while (1) begin
            found = 1'b0;
            r = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && m_q[(model_ptr + k) % NUM_REQ].size() != 0) begin
                    found = 1'b1;
                    r = (model_ptr + k) % NUM_REQ;
                end
            end
            if (!found) break;
            cnt = 0;
            while (m_q[r].size() != 0) begin
                e = m_q[r].pop_front();
                cnt++;
                exp_q.push_back({2'(r), e[7:0]});
                if (e[8] || (MAX_BURST != 0 && cnt == MAX_BURST)) break;
            end
            model_ptr = (r + 1) % NUM_REQ;
        end
    endtask

    task automatic add_byte(input int r, input logic [7:0] b, input bit last);
        src_q[r].push_back({last, b});
    endtask

    task automatic add_pkt(input int r, input int len);
        for (int i = 0; i < len; i++) src_q[r].push_back({(i == len - 1), 8'($urandom)});
    endtask

    // One producer cycle: retire last handshake, maybe open an owner gap, drive offers.
    task automatic step();
        @(negedge i_Clock);
        for (int r = 0; r < NUM_REQ; r++) begin
            if (hs[r] && src_q[r].size() != 0) begin
                last_popped[r] = src_q[r][0][8];
                void'(src_q[r].pop_front());
                grant_bytes[r]++;
            end
            if (!o_Grant[r]) grant_bytes[r] = 0;
            if (gap[r] > 0) begin
                gap[r]--;
            end else if (gap_en && o_Grant[r] && src_q[r].size() != 0 && grant_bytes[r] > 0 &&
                         !last_popped[r] && (MAX_BURST == 0 || grant_bytes[r] < MAX_BURST) &&
                         $urandom_range(0, 5) == 0) begin
                gap[r] = $urandom_range(5, 20);
            end
            i_Req_Valid[r]      = (src_q[r].size() != 0) && (gap[r] == 0);
            i_Req_Byte[8*r +: 8] = (src_q[r].size() != 0) ? src_q[r][0][7:0] : 8'($urandom);
            i_Req_Last[r]       = (src_q[r].size() != 0) ? src_q[r][0][8] : 1'($urandom);
        end
        #1;
        hs = o_Req_Ready & i_Req_Valid;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gap[r] > 0 && o_Grant[r]) begin
                check("gap_no_ready", 32'(o_Req_Ready), 0);
                check("gap_grant_held", 32'(o_Grant[r]), 1);
            end
        end
    endtask

    task automatic run_until_idle(input string name);
        int cyc;
        bit fin;
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 4000) begin
            step();
            cyc++;
            fin = (exp_q.size() == 0) && all_empty() && !o_Busy && !uart_active && !uart_done;
        end
        check({name, "_finished"}, 32'(fin), 1);
        check({name, "_grant_idle"}, 32'(o_Grant), 0);
        check({name, "_busy_idle"}, 32'(o_Busy), 0);
    endtask

    // Monitor: scoreboard on each strobe plus per-cycle handshake and protocol rules.
    always @(posedge i_Clock) begin
        #2;
        if (i_Reset) begin
            stab_en = 1'b0;
            prev_dv = 1'b0;
        end else begin
            check("ready_only_owner", 32'(o_Req_Ready & ~o_Grant), 0);
            check("ready_needs_valid", 32'(o_Req_Ready & ~i_Req_Valid), 0);
            check("grant_onehot", 32'($onehot0(o_Grant)), 1);
            if (o_Grant != '0) check("busy_with_grant", 32'(o_Busy), 1);
            if (o_TX_DV) begin
                check("dv_single_cycle", 32'(prev_dv), 0);
                check("dv_uart_idle", 32'({uart_active, uart_done}), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_strobe actual=%0h required=none at %0t", o_TX_Byte, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_byte", 32'(o_TX_Byte), 32'(mon_e[7:0]));
                    check("grant_at_strobe", 32'(o_Grant), 32'(1) << mon_e[9:8]);
                end
                strobed_byte = o_TX_Byte;
                stab_en = 1'b1;
            end else if (stab_en && (uart_active || uart_done)) begin
                check("byte_stable", 32'(o_TX_Byte), 32'(strobed_byte));
            end else if (!uart_active && !uart_done) begin
                stab_en = 1'b0;
            end
            prev_dv = o_TX_DV;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        for (int r = 0; r < NUM_REQ; r++) begin
            gap[r] = 0;
            grant_bytes[r] = 0;
            last_popped[r] = 1'b0;
        end
        #1 i_Reset = 1'b1;
        #2;
        check("rst_grant", 32'(o_Grant), 0);
        check("rst_dv", 32'(o_TX_DV), 0);
        check("rst_byte", 32'(o_TX_Byte), 0);
        check("rst_busy", 32'(o_Busy), 0);
        check("rst_ready", 32'(o_Req_Ready), 0);
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b0;

        // Packet 48,49,0A from req0 against a one-byte packet 55 from req1.
        add_byte(0, 8'h48, 1'b0);
        add_byte(0, 8'h49, 1'b0);
        add_byte(0, 8'h0A, 1'b1);
        add_byte(1, 8'h55, 1'b1);
        model_round();
        run_until_idle("two_pkts");

        // Single one-byte packet.
        add_byte(0, 8'h41, 1'b1);
        model_round();
        run_until_idle("single_41");

        // Both always valid with one-byte packets: grants alternate.
        for (int i = 0; i < 4; i++) begin
            add_byte(0, 8'(16 + i), 1'b1);
            add_byte(1, 8'(32 + i), 1'b1);
        end
        model_round();
        run_until_idle("alternate");

        // Long stream hits the burst limit and yields to the other requester.
        add_pkt(0, 7);
        for (int i = 0; i < 3; i++) add_pkt(1, 1);
        model_round();
        run_until_idle("burst_release");

        // Randomized packets with owner valid gaps.
        gap_en = 1'b1;
        for (int n = 0; n < 12; n++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) add_pkt(r, $urandom_range(1, 6));
            end
            model_round();
            run_until_idle("random");
        end
        gap_en = 1'b0;

        // Reset while the uart is shifting data bit 3.
        add_pkt(0, 3);
        add_pkt(1, 1);
        model_round();
        cyc = 0;
        while (!(uart_active && u_cnt / CPB == 4) && cyc < 1000) begin
            step();
            cyc++;
        end
        check("reached_data_bit3", 32'(uart_active && (u_cnt / CPB == 4)), 1);
        i_Reset = 1'b1;
        #1;
        check("midrst_grant", 32'(o_Grant), 0);
        check("midrst_dv", 32'(o_TX_DV), 0);
        check("midrst_byte", 32'(o_TX_Byte), 0);
        check("midrst_busy", 32'(o_Busy), 0);
        check("midrst_ready", 32'(o_Req_Ready), 0);
        for (int r = 0; r < NUM_REQ; r++) begin
            src_q[r].delete();
            gap[r] = 0;
            grant_bytes[r] = 0;
        end
        exp_q.delete();
        hs = '0;
        i_Req_Valid = '0;
        model_ptr = 0;
        repeat (2) @(negedge i_Clock);
        i_Reset = 1'b0;

        add_pkt(1, 2);
        add_pkt(0, 1);
        model_round();
        cyc = 0;
        while ((uart_active || uart_done) && cyc < 200) begin
            step();
            cyc++;
            check("sync_no_ready", 32'(o_Req_Ready), 0);
            check("sync_no_dv", 32'(o_TX_DV), 0);
        end
        run_until_idle("after_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
